input_vc_unit: RTL and testbench
================================

Name: input_vc_unit

Overview:
- Per-input-port virtual-channel buffer unit of the NoC router.
- Accepts flits from the upstream link and stores them in per-VC FIFOs.
- Raises per-VC switch requests, with the latched output port, toward the switch allocator.
- On an allocator grant, dequeues the flit to the crossbar and returns a credit upstream. It is the requester/consumer end of the allocator's request/grant interface.

Parameters:
- vc_Num, 4, number of virtual channels per input port (power of two, >=2)
- BUF_DEPTH, 4, flit slots per VC FIFO (power of two, >=2)

Ports:
- clk  input  1  router clock
- rst_n  input  1  asynchronous active-low reset
- flit_in_valid  input  1  upstream flit present this cycle
- flit_in  input  flit_t  incoming flit
- flit_in_vc  input  $clog2(vc_Num)  target VC of incoming flit
- request_o  output  [vc_Num-1:0]  per-VC switch request to allocator
- out_port_o  output  inout_Port [vc_Num-1:0]  per-VC latched output port (unpacked array), valid while request_o bit set
- grant_i  input  [vc_Num-1:0]  per-VC grant from allocator (expected one-hot or zero)
- flit_out_valid  output  1  registered flit to crossbar valid
- flit_out  output  flit_t  registered dequeued flit
- flit_out_port  output  inout_Port  output port of flit_out
- credit_out_valid  output  1  one-cycle credit pulse to upstream
- credit_out_vc  output  $clog2(vc_Num)  VC of returned credit
- error_o  output  1  sticky protocol error (IVC_ERROR_CHECK_EN only)

Behaviour:
- Reset:
  - All FIFOs empty (pointers/counts 0); every VC state IDLE; latched ports 0.
  - request_o, flit_out_valid, credit_out_valid, credit_out_vc, flit_out, flit_out_port, error_o all 0.
  - Reset asserted mid-packet discards all buffered flits; no credits are returned for them.
- Write:
  - On a clk edge with flit_in_valid=1, flit_in is appended to FIFO[flit_in_vc] if that FIFO is not full, judged on the pre-edge count.
  - A write to a full FIFO is dropped, even if the same VC pops that cycle.
  - A written flit is visible at the FIFO head the next cycle.
- Per-VC FSM, states IDLE and ACTIVE:
  - IDLE, head flit type HEAD or HEADTAIL at front: latch dest_port into out_port_o[vc]; ACTIVE next cycle (1-cycle route stage). No request in IDLE.
  - IDLE, BODY or TAIL at front: protocol error. The flit is popped and discarded next edge and a credit is returned, so the VC cannot deadlock.
  - ACTIVE: request_o[vc] = FIFO non-empty (combinational from registered count).
  - ACTIVE, pop of TAIL or HEADTAIL: IDLE next cycle.
  - Back-to-back packets: a new HEAD behind a popped TAIL takes IDLE (1 cycle) then ACTIVE. Minimum 1 bubble between packets on the same VC.
- Grant:
  - A grant bit is honoured only if the matching request_o bit is set; other grant bits are ignored.
  - Multi-hot grant: only the lowest-index honoured VC is popped.
  - Honoured grant at cycle N pops the head at edge N+1. In cycle N+1: flit_out_valid=1, flit_out/flit_out_port = popped flit/port, credit_out_valid=1, credit_out_vc = VC.
  - Latency: grant to crossbar output is 1 cycle.
  - Discarded-flit pops also pulse credit_out but keep flit_out_valid=0.
  - Priority when a grant pop and an IDLE discard coincide: the grant pop goes first; the discard waits.
- Simultaneous write and pop on the same non-full VC: both occur; count unchanged.
- Wrap-around: pointers are $clog2(BUF_DEPTH) bits wide and wrap naturally; count is $clog2(BUF_DEPTH)+1 bits.
- Steady state: sustained one flit per cycle per port.

Optional Feature:
- IVC_ERROR_CHECK_EN
- Defined: error_o sets sticky on any of the following, and clears only on reset:
  - write to a full FIFO
  - non-head flit at front in IDLE
  - HEAD arriving at an ACTIVE VC's FIFO head position while expecting body/tail
  - multi-hot grant_i
  - grant to a non-requesting VC
- Defined: simulation assertions fire on the same conditions.
- Undefined: error_o tied to 0, no checks. Drop/discard behaviour is identical in both builds.

Decomposition:
- Add to params_noc: flit_type_t enum (HEAD, BODY, TAIL, HEADTAIL); flit_t packed struct {flit_type_t flit_type; inout_Port dest_port; logic [FLIT_DATA_W-1:0] data}; FLIT_DATA_W constant.
- One sub-module: vc_fifo (parameter BUF_DEPTH), a synchronous FIFO with push, pop, head data, full, empty and count, instantiated vc_Num times via generate.
- FSMs, grant decode and output registers live in input_vc_unit.

Test Plan (vc_Num=4, BUF_DEPTH=4):
- HEADTAIL flit dest_port=2 written to VC1 at cycle 0 -> IDLE→ACTIVE. request_o=4'b0010 with out_port_o[1]=2 from cycle 2. grant_i[1] at cycle 2 -> flit_out_valid, flit_out_port=2, credit_out_vc=1 at cycle 3. request_o=0 at cycle 3.
- 5 consecutive writes to VC0 with no grants -> 4 stored, 5th dropped. Count stays 4; error_o=1 if IVC_ERROR_CHECK_EN.
- HEAD, BODY, TAIL on VC2, continuous grants -> 3 flits out on consecutive cycles, credit_out pulses 3 times, VC2 returns to IDLE after the TAIL pop.
- BODY written to idle VC3 -> discarded: credit_out_valid=1 with credit_out_vc=3, flit_out_valid stays 0.
- grant_i=4'b0110 with VC1 and VC2 both requesting -> only VC1 pops.
- Reset pulse with VC0 holding 3 flits -> all outputs 0 immediately; request_o=0 after release, no credits returned.

Source files
------------

// File: rtl/params_noc.sv
// params_noc: shared NoC router types (port encoding and flit format).
package params_noc;
    localparam int PORT_W      = 3;
    localparam int FLIT_DATA_W = 16;

    typedef logic [PORT_W-1:0] inout_Port;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_type_t;

    typedef struct packed {
        flit_type_t             flit_type;
        inout_Port              dest_port;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

    function automatic logic is_head_flit(flit_type_t t);
        return t == HEAD || t == HEADTAIL;
    endfunction

    function automatic logic is_tail_flit(flit_type_t t);
        return t == TAIL || t == HEADTAIL;
    endfunction
endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: per-VC synchronous flit FIFO; head flit is readable combinationally.
module vc_fifo
    import params_noc::*;
#(
    parameter  int BUF_DEPTH = 4,
    localparam int PW        = $clog2(BUF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  flit_t         din,
    output flit_t         dout,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);
    flit_t         mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    assign full  = count == (PW+1)'(BUF_DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(wr) - (PW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/input_vc_unit.sv
// input_vc_unit: per-input-port VC buffers, route latch, switch requests and grant-driven dequeue.
// Defining IVC_ERROR_CHECK_EN adds a sticky protocol error flag and simulation assertions.
module input_vc_unit
    import params_noc::*;
#(
    parameter  int vc_Num    = 4,
    parameter  int BUF_DEPTH = 4,
    localparam int VC_W      = $clog2(vc_Num),
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flit_in_valid,
    input  flit_t             flit_in,
    input  logic [VC_W-1:0]   flit_in_vc,
    output logic [vc_Num-1:0] request_o,
    output inout_Port         out_port_o [vc_Num],
    input  logic [vc_Num-1:0] grant_i,
    output logic              flit_out_valid,
    output flit_t             flit_out,
    output inout_Port         flit_out_port,
    output logic              credit_out_valid,
    output logic [VC_W-1:0]   credit_out_vc,
    output logic              error_o
);
    typedef enum logic {IDLE, ACTIVE} vc_state_t;

    vc_state_t         state_q [vc_Num];
    vc_state_t         state_d [vc_Num];
    inout_Port         port_d  [vc_Num];
    flit_t             head    [vc_Num];
    logic [CNT_W-1:0]  count   [vc_Num];
    logic [vc_Num-1:0] push, pop, full, empty, honoured, discard;
    logic [VC_W-1:0]   gsel, dsel, pop_vc;
    logic              gpop, do_pop;

    for (genvar g = 0; g < vc_Num; g++) begin : g_vc
        vc_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (flit_in),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .count (count[g])
        );
    end

    always_comb begin
        request_o = '0;
        discard   = '0;
        push      = '0;
        pop       = '0;
        gsel      = '0;
        dsel      = '0;
        for (int i = 0; i < vc_Num; i++) begin
            request_o[i] = state_q[i] == ACTIVE && count[i] != '0;
            discard[i]   = state_q[i] == IDLE && !empty[i] && !is_head_flit(head[i].flit_type);
            push[i]      = flit_in_valid && flit_in_vc == VC_W'(i) && !full[i];
        end
        honoured = grant_i & request_o;
        // One pop per cycle: lowest granted VC wins, and any grant pre-empts a discard.
        for (int i = vc_Num - 1; i >= 0; i--) begin
            if (honoured[i]) gsel = VC_W'(i);
            if (discard[i]) dsel = VC_W'(i);
        end
        gpop   = |honoured;
        do_pop = gpop || (|discard);
        pop_vc = gpop ? gsel : dsel;
        for (int i = 0; i < vc_Num; i++) begin
            pop[i]     = do_pop && pop_vc == VC_W'(i);
            state_d[i] = state_q[i];
            port_d[i]  = out_port_o[i];
            if (state_q[i] == IDLE && !empty[i] && is_head_flit(head[i].flit_type)) begin
                state_d[i] = ACTIVE;
                port_d[i]  = head[i].dest_port;
            end else if (state_q[i] == ACTIVE && pop[i] && is_tail_flit(head[i].flit_type)) begin
                state_d[i] = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= '{default: IDLE};
            out_port_o       <= '{default: '0};
            flit_out_valid   <= 1'b0;
            flit_out         <= '0;
            flit_out_port    <= '0;
            credit_out_valid <= 1'b0;
            credit_out_vc    <= '0;
        end else begin
            state_q          <= state_d;
            out_port_o       <= port_d;
            flit_out_valid   <= gpop;
            credit_out_valid <= do_pop;
            if (gpop) begin
                flit_out      <= head[gsel];
                flit_out_port <= out_port_o[gsel];
            end
            if (do_pop) credit_out_vc <= pop_vc;
        end
    end

`ifdef IVC_ERROR_CHECK_EN
    logic [vc_Num-1:0] started_q;
    logic              err_now, err_q;

    // A HEAD is only legal at the head of an ACTIVE VC before its packet's first pop.
    always_comb begin
        err_now = (flit_in_valid && full[flit_in_vc]) || ((grant_i & (grant_i - 1'b1)) != '0) ||
                  (|(grant_i & ~request_o));
        for (int i = 0; i < vc_Num; i++)
            err_now |= discard[i] || (state_q[i] == ACTIVE && started_q[i] && !empty[i] &&
                                      is_head_flit(head[i].flit_type));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_q || err_now;
            for (int i = 0; i < vc_Num; i++)
                if (state_q[i] == ACTIVE && pop[i]) started_q[i] <= !is_tail_flit(head[i].flit_type);
        end
    end

    assign error_o = err_q;

    a_no_protocol_error: assert property (@(posedge clk) disable iff (!rst_n) !err_now)
        else $error("input_vc_unit: protocol error");
`else
    assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_input_vc_unit.sv
// tb_input_vc_unit: directed stimulus with an output scoreboard for input_vc_unit.
module tb_input_vc_unit;
    import params_noc::*;

`ifdef IVC_ERROR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic      fv;
        flit_t     flit;
        inout_Port port;
        logic [1:0] vc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flit_in_valid = 1'b0;
    flit_t      flit_in = '0;
    logic [1:0] flit_in_vc = '0;
    logic [3:0] grant_i = '0;
    logic [3:0] request_o;
    inout_Port  out_port_o [4];
    logic       flit_out_valid;
    flit_t      flit_out;
    inout_Port  flit_out_port;
    logic       credit_out_valid;
    logic [1:0] credit_out_vc;
    logic       error_o;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    flit_t t2 [5];
    flit_t t3 [3];
    flit_t f;

    input_vc_unit #(.vc_Num(4), .BUF_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flit_in_valid    (flit_in_valid),
        .flit_in          (flit_in),
        .flit_in_vc       (flit_in_vc),
        .request_o        (request_o),
        .out_port_o       (out_port_o),
        .grant_i          (grant_i),
        .flit_out_valid   (flit_out_valid),
        .flit_out         (flit_out),
        .flit_out_port    (flit_out_port),
        .credit_out_valid (credit_out_valid),
        .credit_out_vc    (credit_out_vc),
        .error_o          (error_o)
    );

    always #5 clk = ~clk;

    function automatic flit_t mk(flit_type_t t, inout_Port p, logic [15:0] d);
        return '{flit_type: t, dest_port: p, data: d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic write(logic [1:0] vc, flit_t fl);
        flit_in_valid = 1'b1;
        flit_in       = fl;
        flit_in_vc    = vc;
        tick();
        flit_in_valid = 1'b0;
    endtask

    task automatic expect_out(logic fv, flit_t fl, inout_Port p, logic [1:0] vc);
        exp_q.push_back('{fv: fv, flit: fl, port: p, vc: vc});
    endtask

    // Every crossbar/credit output is matched against the next queued expectation.
    always @(negedge clk) begin
        if (flit_out_valid || credit_out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: valid=%0b cvalid=%0b cvc=%0d", flit_out_valid,
                         credit_out_valid, credit_out_vc);
            end else begin
                mon_e = exp_q.pop_front();
                if (flit_out_valid !== mon_e.fv || credit_out_valid !== 1'b1 ||
                    credit_out_vc !== mon_e.vc ||
                    (mon_e.fv && (flit_out !== mon_e.flit || flit_out_port !== mon_e.port))) begin
                    errors++;
                    $display("FAIL output: got valid=%0b flit=%h port=%0d cvalid=%0b cvc=%0d, expected valid=%0b flit=%h port=%0d cvc=%0d",
                             flit_out_valid, flit_out, flit_out_port, credit_out_valid, credit_out_vc,
                             mon_e.fv, mon_e.flit, mon_e.port, mon_e.vc);
                end
            end
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_request", 32'(request_o), 0);
        chk("rst_flit_valid", 32'(flit_out_valid), 0);
        chk("rst_credit_valid", 32'(credit_out_valid), 0);
        chk("rst_credit_vc", 32'(credit_out_vc), 0);
        chk("rst_flit_out", 32'(flit_out), 0);
        chk("rst_flit_port", 32'(flit_out_port), 0);
        chk("rst_error", 32'(error_o), 0);
        rst_n = 1'b1;
        tick();

        // single HEADTAIL on VC1
        f = mk(HEADTAIL, 3'd2, 16'h1111);
        write(2'd1, f);
        chk("t1_route_stage_req", 32'(request_o), 0);
        tick();
        chk("t1_req", 32'(request_o), 4'b0010);
        chk("t1_port", 32'(out_port_o[1]), 2);
        grant_i = 4'b0010;
        expect_out(1'b1, f, 3'd2, 2'd1);
        tick();
        grant_i = '0;
        chk("t1_req_after", 32'(request_o), 0);
        tick();

        // overflow VC0: fifth write dropped
        t2[0] = mk(HEAD, 3'd3, 16'hA000);
        t2[1] = mk(BODY, 3'd0, 16'hA001);
        t2[2] = mk(BODY, 3'd0, 16'hA002);
        t2[3] = mk(TAIL, 3'd0, 16'hA003);
        t2[4] = mk(BODY, 3'd0, 16'hA004);
        for (int i = 0; i < 5; i++) write(2'd0, t2[i]);
        chk("t2_req", 32'(request_o), 4'b0001);
        chk("t2_error", 32'(error_o), 32'(ERR_EN));
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_drain", 32'(request_o), 4'b0001);
            grant_i = 4'b0001;
            expect_out(1'b1, t2[i], 3'd3, 2'd0);
            tick();
        end
        grant_i = '0;
        chk("t2_req_empty", 32'(request_o), 0);
        repeat (2) tick();

        // HEAD/BODY/TAIL on VC2 with continuous grants
        t3[0] = mk(HEAD, 3'd1, 16'hB000);
        t3[1] = mk(BODY, 3'd0, 16'hB001);
        t3[2] = mk(TAIL, 3'd0, 16'hB002);
        for (int i = 0; i < 3; i++) write(2'd2, t3[i]);
        for (int i = 0; i < 3; i++) begin
            chk("t3_req", 32'(request_o), 4'b0100);
            grant_i = 4'b0100;
            expect_out(1'b1, t3[i], 3'd1, 2'd2);
            tick();
        end
        grant_i = '0;
        chk("t3_req_idle", 32'(request_o), 0);
        f = mk(HEADTAIL, 3'd4, 16'hB100);
        write(2'd2, f);
        chk("t3_idle_route_stage", 32'(request_o), 0);
        tick();
        chk("t3_req_next_pkt", 32'(request_o), 4'b0100);
        chk("t3_port_next_pkt", 32'(out_port_o[2]), 4);
        grant_i = 4'b0100;
        expect_out(1'b1, f, 3'd4, 2'd2);
        tick();
        grant_i = '0;
        tick();

        // stray BODY on idle VC3 is discarded with a credit
        write(2'd3, mk(BODY, 3'd5, 16'hC000));
        expect_out(1'b0, '0, 3'd0, 2'd3);
        chk("t4_req", 32'(request_o), 0);
        repeat (3) tick();
        chk("t4_req_after", 32'(request_o), 0);

        // multi-hot grant: lowest requesting VC wins
        write(2'd1, mk(HEADTAIL, 3'd5, 16'hD001));
        write(2'd2, mk(HEADTAIL, 3'd6, 16'hD002));
        tick();
        chk("t5_req", 32'(request_o), 4'b0110);
        grant_i = 4'b0110;
        expect_out(1'b1, mk(HEADTAIL, 3'd5, 16'hD001), 3'd5, 2'd1);
        tick();
        grant_i = '0;
        chk("t5_req_vc2_left", 32'(request_o), 4'b0100);
        grant_i = 4'b0100;
        expect_out(1'b1, mk(HEADTAIL, 3'd6, 16'hD002), 3'd6, 2'd2);
        tick();
        grant_i = '0;
        chk("t5_req_none", 32'(request_o), 0);
        tick();

        // reset mid-packet discards buffered flits without credits
        write(2'd0, mk(HEAD, 3'd7, 16'hE000));
        write(2'd0, mk(BODY, 3'd0, 16'hE001));
        write(2'd0, mk(BODY, 3'd0, 16'hE002));
        chk("t6_req", 32'(request_o), 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(request_o), 0);
        chk("t6_rst_port", 32'(out_port_o[0]), 0);
        chk("t6_rst_flit_out", 32'(flit_out), 0);
        chk("t6_rst_flit_port", 32'(flit_out_port), 0);
        chk("t6_rst_credit_vc", 32'(credit_out_vc), 0);
        chk("t6_rst_valid", 32'(flit_out_valid), 0);
        chk("t6_rst_error", 32'(error_o), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t6_req_after", 32'(request_o), 0);
        chk("t6_credit_after", 32'(credit_out_valid), 0);

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
